// File: rtl/fetch_sequencer.sv
// Program counter and one-entry fetch stage for the 19-bit / 12-bit-address core.
// Issues one instruction per cycle and applies jump, call and return redirects.
module fetch_sequencer #(
  parameter int ADDR_W    = 12,
  parameter int INS_W     = 19,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_instruction,
  input  logic              stall,
  input  logic              halt,
  input  logic              resume,
  input  logic              jump_valid,
  input  logic              call_valid,
  input  logic              ret_valid,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [INS_W-1:0]  ins_out,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ras_overflow,
  output logic              ras_underflow,
  output logic [1:0]        state_out
);

  localparam int SP_W = $clog2(RAS_DEPTH);
  localparam logic [SP_W:0] SP_FULL = (SP_W + 1)'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [SP_W:0]     sp;
  logic [ADDR_W-1:0] stack [RAS_DEPTH];

  logic              accept;
  logic              do_ret;
  logic              do_call;
  logic              do_jump;
  logic              push;
  logic [SP_W-1:0]   top_idx;
  logic [ADDR_W-1:0] ret_addr;

  // Redirects only count against an on-path instruction that decode is taking.
  assign accept   = (state == ST_RUN) && !halt && !stall && ins_valid;
  assign do_ret   = accept && ret_valid;
  assign do_call  = accept && !ret_valid && call_valid;
  assign do_jump  = accept && !ret_valid && !call_valid && jump_valid;
  assign push     = do_call && (sp != SP_FULL);
  assign top_idx  = sp[SP_W-1:0] - SP_W'(1);
  assign ret_addr = pc_out + ADDR_W'(1);

  assign imem_addr = pc;
  assign state_out = state;

  // Stack storage is deliberately unreset; sp alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[sp[SP_W-1:0]] <= ret_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_BOOT;
      pc            <= '0;
      sp            <= '0;
      ins_out       <= '0;
      ins_valid     <= 1'b0;
      pc_out        <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (halt) begin
            state     <= ST_HALT;
            ins_valid <= 1'b0;
          end else if (do_ret) begin
            ins_valid <= 1'b0;
            if (sp == '0) begin
              ras_underflow <= 1'b1;
              state         <= ST_FAULT;
            end else begin
              sp <= sp - (SP_W + 1)'(1);
              pc <= stack[top_idx];
            end
          end else if (do_call) begin
            ins_valid <= 1'b0;
            if (sp == SP_FULL) begin
              ras_overflow <= 1'b1;
              state        <= ST_FAULT;
            end else begin
              sp <= sp + (SP_W + 1)'(1);
              pc <= jump_target;
            end
          end else if (do_jump) begin
            ins_valid <= 1'b0;
            pc        <= jump_target;
          end else if (!stall) begin
            ins_out   <= imem_instruction;
            pc_out    <= pc;
            ins_valid <= 1'b1;
            pc        <= pc + ADDR_W'(1);
          end
        end
        ST_HALT: begin
          if (resume && !halt) begin
            state <= ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural program-flow model predicts
// every cycle's outputs, and an independent monitor compares them after each edge.
module tb_fetch_sequencer;

  localparam int AW    = 12;
  localparam int IW    = 19;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_instruction;
  logic          stall, halt, resume;
  logic          jump_valid, call_valid, ret_valid;
  logic [AW-1:0] jump_target;
  logic [IW-1:0] ins_out;
  logic          ins_valid;
  logic [AW-1:0] pc_out;
  logic          ras_overflow, ras_underflow;
  logic [1:0]    state_out;

  logic [IW-1:0] mem [4096];
  assign imem_instruction = mem[imem_addr];

  fetch_sequencer #(.ADDR_W(AW), .INS_W(IW), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instruction(imem_instruction),
    .stall(stall), .halt(halt), .resume(resume), .jump_valid(jump_valid),
    .call_valid(call_valid), .ret_valid(ret_valid), .jump_target(jump_target),
    .ins_out(ins_out), .ins_valid(ins_valid), .pc_out(pc_out),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] pcout;
    logic [IW-1:0] ins;
    logic [1:0]    st;
    logic          of;
    logic          uf;
    logic [AW-1:0] addr;
  } snap_t;

  snap_t exp_q[$];
  int    n_vectors     = 0;
  int    n_miscompares = 0;

  // Reference model: next fetch address, last issued instruction, mode and a queue stack.
  int m_pc, m_pcout, m_ins, m_state;
  bit m_v, m_of, m_uf;
  int ras[$];

  task automatic model_reset();
    m_pc = 0; m_pcout = 0; m_ins = 0; m_state = 0;
    m_v = 0; m_of = 0; m_uf = 0;
    ras.delete();
  endtask

  task automatic model_step(output bit consumed);
    consumed = 0;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (halt) begin
          m_state = 2; m_v = 0; consumed = 1;
        end else if (!stall) begin
          if (m_v && (ret_valid || call_valid || jump_valid)) begin
            consumed = 1; m_v = 0;
            if (ret_valid) begin
              if (ras.size() == 0) begin m_uf = 1; m_state = 3; end
              else m_pc = ras.pop_back();
            end else if (call_valid) begin
              if (ras.size() == DEPTH) begin m_of = 1; m_state = 3; end
              else begin ras.push_back((m_pcout + 1) % 4096); m_pc = int'(jump_target); end
            end else begin
              m_pc = int'(jump_target);
            end
          end else begin
            m_ins = int'(mem[m_pc]); m_pcout = m_pc; m_v = 1; m_pc = (m_pc + 1) % 4096;
          end
        end
      end
      2: if (resume && !halt) m_state = 1;
      default: ;
    endcase
  endtask

  task automatic push_expected();
    snap_t e;
    e.v = m_v; e.pcout = AW'(m_pcout); e.ins = IW'(m_ins); e.st = 2'(m_state);
    e.of = m_of; e.uf = m_uf; e.addr = AW'(m_pc);
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit h, input bit r, input bit s, input bit j,
                                input bit c, input bit rt, input int tgt, output bit consumed);
    @(negedge clk);
    rst = 1'b1; halt = h; resume = r; stall = s;
    jump_valid = j; call_valid = c; ret_valid = rt; jump_target = AW'(tgt);
    model_step(consumed);
    push_expected();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; halt = 0; resume = 0; stall = 0;
    jump_valid = 0; call_valid = 0; ret_valid = 0; jump_target = '0;
    model_reset();
    push_expected();
  endtask

  task automatic idle(input int n);
    bit c;
    for (int k = 0; k < n; k++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, c);
  endtask

  task automatic run_to(input int addr);
    int guard;
    guard = 0;
    while (!(m_v && m_pcout == addr) && guard < 6000) begin
      idle(1);
      guard++;
    end
    if (guard >= 6000) begin
      n_vectors++; n_miscompares++;
      $display("[TB] FAIL run_to: pc_out %0d never issued, got %0h required %0h", addr, m_pcout, addr);
    end
  endtask

  // kind: 0 jump, 1 call, 2 ret; held until the model says it was taken.
  task automatic redirect(input int kind, input int tgt);
    bit c;
    c = 0;
    for (int g = 0; g < 50 && !c; g++) apply_stimulus(0, 0, 0, kind == 0, kind == 1, kind == 2, tgt, c);
    if (!c) begin
      n_vectors++; n_miscompares++;
      $display("[TB] FAIL redirect_timeout: accepted=%0d required=1", c);
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req, inout bit bad);
    if (act !== req) begin
      $display("[TB] FAIL %s at t=%0t: got %0h required %0h", nm, $time, act, req);
      bad = 1;
    end
  endtask

  task automatic check_output(input snap_t e);
    bit bad;
    bad = 0;
    n_vectors++;
    cmp("ins_valid", 32'(ins_valid), 32'(e.v), bad);
    cmp("pc_out", 32'(pc_out), 32'(e.pcout), bad);
    cmp("ins_out", 32'(ins_out), 32'(e.ins), bad);
    cmp("state_out", 32'(state_out), 32'(e.st), bad);
    cmp("ras_overflow", 32'(ras_overflow), 32'(e.of), bad);
    cmp("ras_underflow", 32'(ras_underflow), 32'(e.uf), bad);
    cmp("imem_addr", 32'(imem_addr), 32'(e.addr), bad);
    if (bad) n_miscompares++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  initial begin
    bit c;
    int mask, ptgt;
    bit h, r, s;
    rst = 1'b0; halt = 0; resume = 0; stall = 0;
    jump_valid = 0; call_valid = 0; ret_valid = 0; jump_target = '0;
    for (int i = 0; i < 4096; i++) mem[i] = IW'($urandom_range(1, (1 << IW) - 1));
    model_reset();

    do_reset();
    run_to(5);
    for (int k = 0; k < 3; k++) apply_stimulus(0, 0, 1, 0, 0, 0, 0, c);
    apply_stimulus(0, 0, 1, 1, 0, 0, 77, c);
    idle(3);
    run_to(10);
    redirect(0, 15);
    idle(3);

    do_reset();
    run_to(7);
    redirect(1, 100);
    run_to(101);
    redirect(2, 0);
    idle(3);

    do_reset();
    run_to(2);
    for (int k = 0; k < 9; k++) redirect(1, 200 + 16 * k);
    idle(4);
    do_reset();
    run_to(1);
    redirect(2, 0);
    idle(3);

    do_reset();
    run_to(3);
    redirect(0, 4093);
    run_to(2);
    run_to(20);
    apply_stimulus(1, 0, 1, 1, 0, 0, 300, c);
    idle(3);
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, c);
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, c);
    idle(4);

    mask = 0; ptgt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((m_state == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0) begin
        do_reset();
        mask = 0;
      end else begin
        if (mask == 0 && $urandom_range(0, 5) == 0) begin
          mask = $urandom_range(1, 7);
          ptgt = $urandom_range(0, 4095);
          if (mask[2] && ras.size() == 0 && $urandom_range(0, 7) != 0) mask[2] = 1'b0;
          if (!mask[2] && mask[1] && ras.size() == DEPTH && $urandom_range(0, 7) != 0) mask[1] = 1'b0;
          if (mask == 0) mask = 1;
        end
        h = ($urandom_range(0, 39) == 0);
        r = ($urandom_range(0, 2) == 0);
        s = ($urandom_range(0, 4) == 0);
        apply_stimulus(h, r, s, mask[0], mask[1], mask[2], ptgt, c);
        if (c) mask = 0;
      end
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vectors++; n_miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
